// File: rtl/dvp_pattern_tx.sv
// dvp_pattern_tx
//   Emulates an OV5640-style camera's DVP output for bring-up and simulation.
//   It generates a pixel clock, VSYNC/HREF framing and an 8-bit byte stream
//   carrying RGB565 test patterns (high byte first). Data is meant to be taken
//   by the receiver on the rising PCLK edge while VSYNC & HREF are high.
//
// Parameters
//   H_ACTIVE  active pixels per line (multiple of 8)
//   H_BLANK   blank PCLK periods after the active bytes of each line
//   V_ACTIVE  active lines per frame
//   V_BLANK   blank lines ahead of each frame's active region
//
// Ports
//   CMOS_XCLK    in   block clock
//   cmos_rst_n   in   asynchronous active-low reset
//   enable       in   run request, sampled in IDLE and at frame end
//   pat_mode     in   0 bars, 1 checker (16 px), 2 horizontal ramp, 3 solid
//   pat_color    in   RGB565 colour used by solid mode
//   CMOS_PCLK    out  pixel clock, CMOS_XCLK/2
//   CMOS_VSYNC   out  high over the active region of a frame
//   CMOS_HREF    out  high during the active bytes of a line
//   CMOS_DB      out  byte data, 0 whenever HREF is low
//   frame_start  out  one-XCLK pulse on entry to the active region
//   frame_cnt    out  completed-frame counter, wraps
module dvp_pattern_tx #(
    parameter int H_ACTIVE = 640,
    parameter int H_BLANK  = 144,
    parameter int V_ACTIVE = 480,
    parameter int V_BLANK  = 8
) (
    input  logic        CMOS_XCLK,
    input  logic        cmos_rst_n,
    input  logic        enable,
    input  logic [1:0]  pat_mode,
    input  logic [15:0] pat_color,
    output logic        CMOS_PCLK,
    output logic        CMOS_VSYNC,
    output logic        CMOS_HREF,
    output logic [7:0]  CMOS_DB,
    output logic        frame_start,
    output logic [15:0] frame_cnt
);

    localparam int LINE_TICKS = 2 * H_ACTIVE + H_BLANK;
    localparam int COL_W      = $clog2(LINE_TICKS);
    localparam int V_MAX      = (V_ACTIVE > V_BLANK) ? V_ACTIVE : V_BLANK;
    localparam int LINE_W     = $clog2(V_MAX + 1);
    localparam int BAR_BYTES  = H_ACTIVE / 4;
    localparam int BCNT_W     = (BAR_BYTES > 1) ? $clog2(BAR_BYTES) : 1;

    localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(LINE_TICKS - 1);
    localparam logic [COL_W-1:0]  HREF_END  = COL_W'(2 * H_ACTIVE);
    localparam logic [LINE_W-1:0] VB_LAST   = LINE_W'(V_BLANK - 1);
    localparam logic [LINE_W-1:0] VA_LAST   = LINE_W'(V_ACTIVE - 1);
    localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(BAR_BYTES - 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_VBLANK = 2'd1;
    localparam logic [1:0] S_ACTIVE = 2'd2;

    logic              pclk_r;
    logic [1:0]        state_q, state_n;
    logic [COL_W-1:0]  col_q, col_n;
    logic [LINE_W-1:0] line_q, line_n;
    logic [2:0]        bar_q, bar_n;
    logic [BCNT_W-1:0] bcnt_q, bcnt_n;
    logic [1:0]        mode_q, mode_use;
    logic [15:0]       color_q, color_use;
    logic              frame_enter, frame_done;
    logic              href_n;
    logic [15:0]       x_n, y_n, pix_n;
    logic [7:0]        db_n;

    assign CMOS_PCLK = pclk_r;

    function automatic logic [15:0] pattern_pixel(
        input logic [1:0]  mode,
        input logic [15:0] color,
        input logic [2:0]  bar,
        input logic [15:0] x,
        input logic [15:0] y
    );
        logic [15:0] p;
        case (mode)
            2'd0: begin
                case (bar)
                    3'd0:    p = 16'hF800;
                    3'd1:    p = 16'h07E0;
                    3'd2:    p = 16'h001F;
                    3'd3:    p = 16'hF81F;
                    3'd4:    p = 16'hFFE0;
                    3'd5:    p = 16'h07FF;
                    3'd6:    p = 16'hFFFF;
                    default: p = 16'h0000;
                endcase
            end
            2'd1:    p = (x[4] ^ y[4]) ? 16'h0000 : 16'hFFFF;
            2'd2:    p = {x[6:2], x[6:1], x[6:2]};
            default: p = color;
        endcase
        return p;
    endfunction

    // Next-position computation: everything below describes the bus state
    // that will be presented after the coming tick.
    always_comb begin
        state_n     = state_q;
        col_n       = col_q;
        line_n      = line_q;
        frame_enter = 1'b0;
        frame_done  = 1'b0;
        case (state_q)
            S_IDLE: begin
                col_n  = '0;
                line_n = '0;
                if (enable) state_n = S_VBLANK;
            end
            S_VBLANK: begin
                if (col_q == COL_LAST) begin
                    col_n = '0;
                    if (line_q == VB_LAST) begin
                        line_n      = '0;
                        state_n     = S_ACTIVE;
                        frame_enter = 1'b1;
                    end else begin
                        line_n = line_q + LINE_W'(1);
                    end
                end else begin
                    col_n = col_q + COL_W'(1);
                end
            end
            S_ACTIVE: begin
                if (col_q == COL_LAST) begin
                    col_n = '0;
                    if (line_q == VA_LAST) begin
                        line_n     = '0;
                        frame_done = 1'b1;
                        state_n    = enable ? S_VBLANK : S_IDLE;
                    end else begin
                        line_n = line_q + LINE_W'(1);
                    end
                end else begin
                    col_n = col_q + COL_W'(1);
                end
            end
            default: begin
                state_n = S_IDLE;
                col_n   = '0;
                line_n  = '0;
            end
        endcase

        // Bar index tracks col_n/(2*H_ACTIVE/8) by counting bytes per bar.
        if (col_n == '0) begin
            bar_n  = '0;
            bcnt_n = '0;
        end else if (bcnt_q == BCNT_LAST) begin
            bar_n  = bar_q + 3'd1;
            bcnt_n = '0;
        end else begin
            bar_n  = bar_q;
            bcnt_n = bcnt_q + BCNT_W'(1);
        end

        // The first active byte is produced on the entry tick itself, before
        // the latched copy is written, so it reads the inputs directly.
        mode_use  = frame_enter ? pat_mode  : mode_q;
        color_use = frame_enter ? pat_color : color_q;

        href_n = (state_n == S_ACTIVE) && (col_n < HREF_END);
        x_n    = 16'(col_n >> 1);
        y_n    = 16'(line_n);
        pix_n  = pattern_pixel(mode_use, color_use, bar_n, x_n, y_n);
        if (!href_n)
            db_n = 8'h00;
        else if (col_n[0])
            db_n = pix_n[7:0];
        else
            db_n = pix_n[15:8];
    end

    // Registered outputs and control, advanced on falling-PCLK ticks.
    always_ff @(posedge CMOS_XCLK or negedge cmos_rst_n) begin
        if (!cmos_rst_n) begin
            pclk_r      <= 1'b0;
            state_q     <= S_IDLE;
            col_q       <= '0;
            line_q      <= '0;
            bar_q       <= '0;
            bcnt_q      <= '0;
            CMOS_VSYNC  <= 1'b0;
            CMOS_HREF   <= 1'b0;
            CMOS_DB     <= 8'h00;
            frame_start <= 1'b0;
            frame_cnt   <= 16'h0000;
        end else begin
            pclk_r      <= ~pclk_r;
            frame_start <= pclk_r & frame_enter;
            if (pclk_r) begin
                state_q    <= state_n;
                col_q      <= col_n;
                line_q     <= line_n;
                bar_q      <= bar_n;
                bcnt_q     <= bcnt_n;
                CMOS_VSYNC <= (state_n == S_ACTIVE);
                CMOS_HREF  <= href_n;
                CMOS_DB    <= db_n;
                if (frame_done) frame_cnt <= frame_cnt + 16'd1;
            end
        end
    end

    // Pattern selection held for the whole frame.
    always_ff @(posedge CMOS_XCLK) begin
        if (pclk_r && frame_enter) begin
            mode_q  <= pat_mode;
            color_q <= pat_color;
        end
    end

endmodule

// File: tb/tb_dvp_pattern_tx.sv
module tb_dvp_pattern_tx;

    localparam int HA  = 16;
    localparam int HB  = 4;
    localparam int VA  = 4;
    localparam int VB  = 2;
    localparam int L   = 2 * HA + HB;
    localparam int VBT = VB * L;
    localparam int FT  = (VB + VA) * L;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic [1:0]  pat_mode = 2'd0;
    logic [15:0] pat_color = 16'h0000;
    logic        CMOS_PCLK, CMOS_VSYNC, CMOS_HREF, frame_start;
    logic [7:0]  CMOS_DB;
    logic [15:0] frame_cnt;

    always #5 clk = ~clk;

    dvp_pattern_tx #(.H_ACTIVE(HA), .H_BLANK(HB), .V_ACTIVE(VA), .V_BLANK(VB)) dut (
        .CMOS_XCLK  (clk),
        .cmos_rst_n (rst_n),
        .enable     (enable),
        .pat_mode   (pat_mode),
        .pat_color  (pat_color),
        .CMOS_PCLK  (CMOS_PCLK),
        .CMOS_VSYNC (CMOS_VSYNC),
        .CMOS_HREF  (CMOS_HREF),
        .CMOS_DB    (CMOS_DB),
        .frame_start(frame_start),
        .frame_cnt  (frame_cnt)
    );

    int tests = 0;
    int fails = 0;
    int fs_count = 0;
    logic [7:0]  line0 [0:2*HA-1];

    // Behavioural 8-to-16 capture: bytes taken on rising PCLK while VSYNC & HREF.
    logic        cap_phase = 1'b0;
    logic [7:0]  cap_hi = 8'h00;
    logic [15:0] cap_q [$];

    always @(posedge CMOS_PCLK) begin
        if (CMOS_VSYNC && CMOS_HREF) begin
            if (!cap_phase) cap_hi <= CMOS_DB;
            else            cap_q.push_back({cap_hi, CMOS_DB});
            cap_phase <= ~cap_phase;
        end else begin
            cap_phase <= 1'b0;
        end
    end

    always @(negedge clk) if (frame_start) fs_count <= fs_count + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] ref_pix(input int mode, input logic [15:0] color,
                                            input int x, input int y);
        int r, g;
        case (mode)
            0: begin
                case (x / (HA / 8))
                    0: return 16'hF800;
                    1: return 16'h07E0;
                    2: return 16'h001F;
                    3: return 16'hF81F;
                    4: return 16'hFFE0;
                    5: return 16'h07FF;
                    6: return 16'hFFFF;
                    default: return 16'h0000;
                endcase
            end
            1: return ((((x / 16) % 2) ^ ((y / 16) % 2)) != 0) ? 16'h0000 : 16'hFFFF;
            2: begin
                r = (x / 4) % 32;
                g = (x / 2) % 64;
                return 16'((r << 11) | (g << 5) | r);
            end
            default: return color;
        endcase
    endfunction

    // Advance to the sample point just after the next falling-PCLK tick.
    task automatic next_tick();
        logic prev, cur;
        prev = CMOS_PCLK;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            cur = CMOS_PCLK;
            if (prev === 1'b1 && cur === 1'b0) return;
            prev = cur;
        end
        tests++;
        fails++;
        $error("FAIL tick_timeout observed=no_tick expected=tick");
    endtask

    // Walk one frame tick by tick from the enable-sampling / frame-wrap tick.
    task automatic run_frame(input int mode, input logic [15:0] color, input int last_p,
                             input int poke_p, input logic [15:0] poke_color,
                             input int drop_p, input logic [15:0] cnt0);
        int line, col, fs0;
        logic vs, hr;
        logic [7:0]  db;
        logic [15:0] px;
        fs0 = fs_count;
        for (int p = 0; p <= last_p; p++) begin
            next_tick();
            line = p / L;
            col  = p % L;
            vs   = (p >= VBT);
            hr   = vs && (col < 2 * HA);
            db   = 8'h00;
            if (hr) begin
                px = ref_pix(mode, color, col / 2, line - VB);
                db = (col % 2 == 1) ? px[7:0] : px[15:8];
            end
            chk($sformatf("frame_p%0d_vs_href_db", p),
                {22'd0, CMOS_VSYNC, CMOS_HREF, CMOS_DB}, {22'd0, vs, hr, db});
            if (p == 0)   chk("frame_cnt_at_start", {16'd0, frame_cnt}, {16'd0, cnt0});
            if (p == VBT) chk("frame_start_at_vsync_rise", {31'd0, frame_start}, 32'd1);
            if (vs && line == VB && hr) line0[col] = CMOS_DB;
            if (p == poke_p) pat_color = poke_color;
            if (p == drop_p) enable = 1'b0;
        end
        if (last_p == FT - 1) chk("frame_start_once", fs_count - fs0, 32'd1);
    endtask

    initial begin
        int fs_idle;
        logic prev;

        // Reset state.
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", {4'd0, CMOS_PCLK, CMOS_VSYNC, CMOS_HREF, CMOS_DB, frame_start, frame_cnt}, 32'd0);

        // Idle with enable low.
        @(negedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 200; i++) begin
            prev = CMOS_PCLK;
            @(negedge clk);
            chk("idle_pclk_toggle", {31'd0, CMOS_PCLK}, {31'd0, ~prev});
            chk("idle_outputs", {6'd0, CMOS_VSYNC, CMOS_HREF, CMOS_DB, frame_cnt}, 32'd0);
        end

        // Colour bars, framing.
        pat_mode = 2'd0;
        enable   = 1'b1;
        run_frame(0, 16'h0000, FT - 1, -1, 16'h0000, -1, 16'd0);
        chk("bars_b0", {24'd0, line0[0]}, 32'hF8);
        chk("bars_b1", {24'd0, line0[1]}, 32'h00);
        chk("bars_b2", {24'd0, line0[2]}, 32'hF8);
        chk("bars_b3", {24'd0, line0[3]}, 32'h00);
        chk("bars_b4", {24'd0, line0[4]}, 32'h07);
        chk("bars_b5", {24'd0, line0[5]}, 32'hE0);
        chk("bars_b6", {24'd0, line0[6]}, 32'h07);
        chk("bars_b7", {24'd0, line0[7]}, 32'hE0);
        chk("bars_last_hi", {24'd0, line0[2*HA-2]}, 32'h00);
        chk("bars_last_lo", {24'd0, line0[2*HA-1]}, 32'h00);

        // Solid colour, mid-frame change held off until the next frame.
        pat_mode  = 2'd3;
        pat_color = 16'hABCD;
        run_frame(3, 16'hABCD, FT - 1, VBT + 28, 16'h1234, -1, 16'd1);

        // Next frame shows the new colour; enable drops during line 1.
        run_frame(3, 16'h1234, FT - 1, -1, 16'h0000, VBT + L + 5, 16'd2);

        // Back in IDLE: no further VSYNC.
        fs_idle = fs_count;
        for (int i = 0; i < 250; i++) begin
            next_tick();
            if (i == 0) chk("stop_frame_cnt", {16'd0, frame_cnt}, 32'd3);
            chk("stop_idle_outputs", {22'd0, CMOS_VSYNC, CMOS_HREF, CMOS_DB}, 32'd0);
        end
        chk("stop_no_frame_start", fs_count - fs_idle, 32'd0);

        // Checker pattern with capture loopback.
        pat_mode  = 2'd1;
        pat_color = 16'h0000;
        enable    = 1'b1;
        cap_q.delete();
        run_frame(1, 16'h0000, FT - 1, -1, 16'h0000, -1, 16'd3);
        chk("loop_word_count", cap_q.size(), HA * VA);
        for (int i = 0; i < HA * VA; i++) begin
            if (i < cap_q.size())
                chk($sformatf("loop_px%0d", i), {16'd0, cap_q[i]}, {16'd0, ref_pix(1, 16'h0000, i % HA, i / HA)});
        end

        // Async reset mid-line while HREF is high.
        pat_mode = 2'd2;
        run_frame(2, 16'h0000, VBT + 3, -1, 16'h0000, -1, 16'd4);
        chk("pre_reset_href", {31'd0, CMOS_HREF}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_outputs",
            {4'd0, CMOS_PCLK, CMOS_VSYNC, CMOS_HREF, CMOS_DB, frame_start, frame_cnt}, 32'd0);
        @(negedge clk);
        #1 rst_n = 1'b1;

        // Framing restarts from IDLE (ramp pattern).
        run_frame(2, 16'h0000, FT - 1, -1, 16'h0000, -1, 16'd0);
        next_tick();
        chk("restart_frame_cnt", {16'd0, frame_cnt}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
